nat_sum_dispatcher: RTL and testbench

//  Upstream request stage for the natural-number-sum Datapath. Buffers incoming N requests
//  in a small FIFO and issues them one at a time as a single-cycle N_valid pulse with N held

---
 rtl/nat_sum_dispatcher.sv | 178 +++++++++++++++++
 tb/tb_nat_sum_dispatcher.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nat_sum_dispatcher.sv
// Request stage for the natural-number-sum datapath: FIFO-buffers N requests, issues them one at
// a time, waits for the sum (with a timeout) and returns a checked result on a valid/ready port.
`timescale 1ns/1ps

module nat_sum_dispatcher #(
    parameter int unsigned N_WIDTH        = 8,
    parameter int unsigned SUM_WIDTH      = 18,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic [N_WIDTH-1:0]          Req_N,
    input  logic                        Req_valid,
    output logic                        Req_ready,
    output logic [N_WIDTH-1:0]          N,
    output logic                        N_valid,
    input  logic [SUM_WIDTH-1:0]        Sum_in,
    input  logic                        Sum_valid,
    output logic [N_WIDTH-1:0]          Res_N,
    output logic [SUM_WIDTH-1:0]        Res_sum,
    output logic                        Res_timeout,
    output logic                        Res_mismatch,
    output logic                        Res_valid,
    input  logic                        Res_ready,
    output logic                        Busy,
    output logic [$clog2(FIFO_DEPTH):0] Fifo_count
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TmrW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned ExpW = SUM_WIDTH + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q;
    logic [N_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     count_q, count_d;
    logic                push, pop;

    logic [N_WIDTH-1:0]   n_q;
    logic                 n_valid_q;
    logic [TmrW-1:0]      wait_cnt_q;
    logic                 armed_q;
    logic [N_WIDTH-1:0]   res_n_q;
    logic [SUM_WIDTH-1:0] res_sum_q;
    logic                 res_timeout_q;
    logic                 res_mismatch_q;
    logic                 res_valid_q;
    logic                 busy_q;

    logic [ExpW-1:0]      n_ext;
    logic [ExpW-1:0]      exp_sum;
    logic                 mismatch;

    // Ready comes from the registered count, so a full FIFO refuses even on a same-cycle pop.
    assign Req_ready = (count_q != CntFull);
    assign push      = Req_valid && Req_ready;
    assign pop       = (state_q == StIssue);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= Req_N;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        n_ext    = ExpW'(n_q);
        exp_sum  = (n_ext * (n_ext + ExpW'(1))) >> 1;
        mismatch = ({1'b0, Sum_in} != exp_sum);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q        <= StIdle;
            n_q            <= '0;
            n_valid_q      <= 1'b0;
            wait_cnt_q     <= '0;
            armed_q        <= 1'b0;
            res_n_q        <= '0;
            res_sum_q      <= '0;
            res_timeout_q  <= 1'b0;
            res_mismatch_q <= 1'b0;
            res_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        n_q       <= mem_q[rd_ptr_q];
                        n_valid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    n_valid_q  <= 1'b0;
                    wait_cnt_q <= '0;
                    armed_q    <= 1'b0;
                    state_q    <= StWait;
                end
                StWait: begin
                    // A low sample proves any earlier level-high Sum_valid has gone away.
                    if (!Sum_valid) begin
                        armed_q <= 1'b1;
                    end
                    if (armed_q && Sum_valid) begin
                        res_n_q        <= n_q;
                        res_sum_q      <= Sum_in;
                        res_timeout_q  <= 1'b0;
                        res_mismatch_q <= mismatch;
                        res_valid_q    <= 1'b1;
                        state_q        <= StResp;
                    end else if (wait_cnt_q == TmrLast) begin
                        res_n_q        <= n_q;
                        res_sum_q      <= '0;
                        res_timeout_q  <= 1'b1;
                        res_mismatch_q <= 1'b0;
                        res_valid_q    <= 1'b1;
                        state_q        <= StResp;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    if (Res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign N            = n_q;
    assign N_valid      = n_valid_q;
    assign Res_N        = res_n_q;
    assign Res_sum      = res_sum_q;
    assign Res_timeout  = res_timeout_q;
    assign Res_mismatch = res_mismatch_q;
    assign Res_valid    = res_valid_q;
    assign Busy         = busy_q;
    assign Fifo_count   = count_q;

endmodule

// File: tb/tb_nat_sum_dispatcher.sv
// Bench for nat_sum_dispatcher: datapath model, in-order result scoreboard, vector table and
// hand-written sequences for backpressure, timeout, stale Sum_valid and mid-job reset.
`timescale 1ns/1ps

module tb_nat_sum_dispatcher;

    localparam int NW = 8;
    localparam int SW = 18;
    localparam int FD = 4;
    localparam int TO = 1024;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic [NW-1:0] Req_N;
    logic          Req_valid;
    logic          Req_ready;
    logic [NW-1:0] N;
    logic          N_valid;
    logic [SW-1:0] Sum_in;
    logic          Sum_valid;
    logic [NW-1:0] Res_N;
    logic [SW-1:0] Res_sum;
    logic          Res_timeout;
    logic          Res_mismatch;
    logic          Res_valid;
    logic          Res_ready;
    logic          Busy;
    logic [$clog2(FD):0] Fifo_count;

    nat_sum_dispatcher #(
        .N_WIDTH       (NW),
        .SUM_WIDTH     (SW),
        .FIFO_DEPTH    (FD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Req_N       (Req_N),
        .Req_valid   (Req_valid),
        .Req_ready   (Req_ready),
        .N           (N),
        .N_valid     (N_valid),
        .Sum_in      (Sum_in),
        .Sum_valid   (Sum_valid),
        .Res_N       (Res_N),
        .Res_sum     (Res_sum),
        .Res_timeout (Res_timeout),
        .Res_mismatch(Res_mismatch),
        .Res_valid   (Res_valid),
        .Res_ready   (Res_ready),
        .Busy        (Busy),
        .Fifo_count  (Fifo_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int n;
        int sum;
        bit to;
        bit mm;
    } exp_t;

    typedef struct {
        int n;
        int sum;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t res_q[$];
    int   iss_q[$];
    int   res_log_n[$];
    int   res_log_sum[$];
    int   res_cnt = 0;
    int   issued_cnt = 0;
    int   nvalid_cyc = 0;
    int   res_rise_cyc = 0;
    int   last_n = 0;
    int   last_sum = 0;
    bit   last_to = 0;
    bit   last_mm = 0;
    int   dp_mode = 0;   // 0: correct sum, 1: never answers, 2: driven by hand
    int   dp_lat = 2;
    bit   dp_rand = 0;
    int   man_sum = 0;
    bit   man_mm = 0;
    bit   rr_force = 1;
    bit   rr_val = 0;
    bit   rv_prev = 0;
    bit   nv_prev = 0;
    bit   drop_pend = 0;

    always @(posedge Clk) cyc++;

    function automatic int tri_sum(input int n);
        return (n * (n + 1)) / 2;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    // Called at posedge+2; leaves Req_valid low unless the next push follows immediately.
    task automatic push(input int n);
        bit ok;
        int waited;
        ok = 0;
        waited = 0;
        Req_valid = 1'b1;
        Req_N = NW'(n);
        while (!ok && waited < 2000) begin
            @(negedge Clk);
            if (Req_ready === 1'b1) begin
                ok = 1;
                iss_q.push_back(n);
            end else begin
                waited++;
            end
            @(posedge Clk);
            #2;
        end
        Req_valid = 1'b0;
        if (!ok) chk("push_accept", 0, 1);
    endtask

    task automatic wait_results(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (res_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, res_cnt, target);
    endtask

    task automatic wait_issue(input string name);
        int base;
        int n;
        base = issued_cnt;
        n = 0;
        while (issued_cnt == base && n < 50) begin
            tick(1);
            n++;
        end
        chk(name, issued_cnt, base + 1);
    endtask

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            Res_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Datapath model: answers each N_valid pulse according to dp_mode.
    initial begin
        Sum_valid = 1'b0;
        Sum_in = '0;
        forever begin
            @(negedge Clk);
            if (Rst_n === 1'b1 && N_valid === 1'b1) begin
                int nref;
                int lat;
                exp_t e;
                issued_cnt++;
                nvalid_cyc = cyc;
                nref = (iss_q.size() != 0) ? iss_q.pop_front() : -1;
                chk("issue_order", int'(N), nref);
                e.n = nref;
                case (dp_mode)
                    0: begin e.sum = tri_sum(nref); e.to = 0; e.mm = 0; end
                    1: begin e.sum = 0; e.to = 1; e.mm = 0; end
                    default: begin e.sum = man_sum; e.to = 0; e.mm = man_mm; end
                endcase
                res_q.push_back(e);
                if (dp_mode == 0) begin
                    lat = dp_rand ? int'($urandom_range(2, 6)) : dp_lat;
                    repeat (lat) @(posedge Clk);
                    #2;
                    chk("n_held", int'(N), nref);
                    Sum_valid = 1'b1;
                    Sum_in = SW'(tri_sum(int'(N)));
                    @(posedge Clk);
                    #2;
                    Sum_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (nv_prev) chk("nvalid_one_cycle", int'(N_valid), 0);
            nv_prev = (N_valid === 1'b1);
        end
    end

    // Result scoreboard: every accepted result must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge Clk);
            if (drop_pend) begin
                chk("res_valid_drop", int'(Res_valid), 0);
                drop_pend = 0;
            end
            if (Res_valid === 1'b1 && !rv_prev) res_rise_cyc = cyc;
            rv_prev = (Res_valid === 1'b1);
            if (Res_valid === 1'b1 && Res_ready === 1'b1) begin
                exp_t e;
                if (res_q.size() == 0) e = '{-1, -1, 1'b0, 1'b0};
                else e = res_q.pop_front();
                chk("res_n", int'(Res_N), e.n);
                chk("res_sum", int'(Res_sum), e.sum);
                chk("res_timeout", int'(Res_timeout), int'(e.to));
                chk("res_mismatch", int'(Res_mismatch), int'(e.mm));
                res_log_n.push_back(int'(Res_N));
                res_log_sum.push_back(int'(Res_sum));
                last_n = int'(Res_N);
                last_sum = int'(Res_sum);
                last_to = Res_timeout;
                last_mm = Res_mismatch;
                res_cnt++;
                drop_pend = 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        int   base;
        int   issued_base;

        vecs[0] = '{10, 55};
        vecs[1] = '{5, 15};
        vecs[2] = '{255, 32640};
        vecs[3] = '{0, 0};
        vecs[4] = '{1, 1};
        vecs[5] = '{2, 3};
        vecs[6] = '{100, 5050};
        vecs[7] = '{128, 8256};

        Rst_n = 1'b0;
        Req_valid = 1'b0;
        Req_N = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_req_ready", int'(Req_ready), 1);
        chk("rst_fifo_count", int'(Fifo_count), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_n_valid", int'(N_valid), 0);
        chk("rst_n", int'(N), 0);
        chk("rst_res_valid", int'(Res_valid), 0);
        chk("rst_res_sum", int'(Res_sum), 0);
        @(posedge Clk);
        #2;
        Rst_n = 1'b1;
        tick(2);

        // Single request with a fixed-latency datapath.
        rr_force = 1;
        rr_val = 1;
        push(10);
        wait_results("t1_result", 1, 100);
        chk("t1_sum", last_sum, 55);
        chk("t1_n", last_n, 10);
        chk("t1_mismatch", int'(last_mm), 0);
        chk("t1_res_latency", res_rise_cyc - nvalid_cyc, dp_lat + 1);

        // Vector table, first four back-to-back, random result backpressure.
        rr_force = 0;
        base = res_cnt;
        for (int i = 0; i < 8; i++) push(vecs[i].n);
        wait_results("t2_results", base + 8, 1000);
        for (int i = 0; i < 8; i++) begin
            if (base + i < res_log_sum.size()) begin
                chk("t2_vec_n", res_log_n[base + i], vecs[i].n);
                chk("t2_vec_sum", res_log_sum[base + i], vecs[i].sum);
            end
        end

        // FIFO fills while the result port is stalled.
        rr_force = 1;
        rr_val = 0;
        tick(2);
        base = res_cnt;
        for (int i = 1; i <= 5; i++) push(i);
        tick(20);
        @(negedge Clk);
        chk("t3_fifo_full", int'(Fifo_count), FD);
        chk("t3_req_ready_low", int'(Req_ready), 0);
        chk("t3_res_valid_held", int'(Res_valid), 1);
        chk("t3_busy", int'(Busy), 1);
        @(posedge Clk);
        #2;
        Req_valid = 1'b1;
        Req_N = NW'(6);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("t3_refuse_push", int'(Req_ready), 0);
            @(posedge Clk);
            #2;
        end
        rr_val = 1;
        push(6);
        wait_results("t3_results", base + 6, 500);
        for (int i = 0; i < 6; i++) begin
            if (base + i < res_log_n.size()) chk("t3_order", res_log_n[base + i], i + 1);
        end

        // Random requests, gaps, latencies and backpressure.
        rr_force = 0;
        dp_rand = 1;
        base = res_cnt;
        for (int i = 0; i < 30; i++) begin
            push(int'($urandom_range(0, 255)));
            tick(int'($urandom_range(0, 3)));
        end
        wait_results("rand_results", base + 30, 3000);
        dp_rand = 0;

        // Datapath never answers.
        rr_force = 1;
        rr_val = 1;
        dp_mode = 1;
        base = res_cnt;
        push(77);
        wait_results("t4_result", base + 1, TO + 200);
        chk("t4_timeout", int'(last_to), 1);
        chk("t4_sum", last_sum, 0);
        chk("t4_mismatch", int'(last_mm), 0);
        chk("t4_n", last_n, 77);
        chk("t4_wait_cycles", res_rise_cyc - nvalid_cyc, TO + 1);

        // Stale level-high Sum_valid carried into the next job, then a wrong sum.
        dp_mode = 2;
        man_sum = 6;
        man_mm = 0;
        base = res_cnt;
        push(3);
        wait_issue("t5_issue_a");
        tick(1);
        Sum_valid = 1'b1;
        Sum_in = SW'(6);
        wait_results("t5_result_a", base + 1, 50);
        chk("t5_sum_a", last_sum, 6);
        man_sum = 56;
        man_mm = 1;
        push(10);
        wait_issue("t5_issue_b");
        tick(5);
        @(negedge Clk);
        chk("t5_stale_ignored", int'(Res_valid), 0);
        chk("t5_busy", int'(Busy), 1);
        @(posedge Clk);
        #2;
        Sum_valid = 1'b0;
        tick(1);
        Sum_valid = 1'b1;
        Sum_in = SW'(56);
        tick(1);
        Sum_valid = 1'b0;
        Sum_in = '0;
        wait_results("t5_result_b", base + 2, 50);
        chk("t5_sum_b", last_sum, 56);
        chk("t5_mismatch_b", int'(last_mm), 1);

        // Reset in the middle of WAIT with two requests queued.
        dp_mode = 1;
        push(20);
        push(21);
        push(22);
        tick(6);
        @(negedge Clk);
        chk("t6_busy_before", int'(Busy), 1);
        chk("t6_queued_before", int'(Fifo_count), 2);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("t6_rst_fifo_count", int'(Fifo_count), 0);
        chk("t6_rst_busy", int'(Busy), 0);
        chk("t6_rst_n", int'(N), 0);
        chk("t6_rst_n_valid", int'(N_valid), 0);
        chk("t6_rst_res_valid", int'(Res_valid), 0);
        chk("t6_rst_req_ready", int'(Req_ready), 1);
        iss_q.delete();
        res_q.delete();
        tick(2);
        Rst_n = 1'b1;
        base = res_cnt;
        issued_base = issued_cnt;
        tick(TO + 50);
        @(negedge Clk);
        chk("t6_no_result", res_cnt, base);
        chk("t6_no_issue", issued_cnt, issued_base);
        chk("t6_idle", int'(Busy), 0);
        chk("t6_empty", int'(Fifo_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
